// File: rtl/spi_reg_bank_pkg.sv
// Shared constants, FSM state encoding and address helper for the SPI register bank.
package spi_reg_bank_pkg;

  localparam int HDR_W       = 8;
  localparam int RW_BIT      = 7;
  localparam int ADDR_W      = 7;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Burst address step: wraps from the last implemented register back to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input int num_regs);
    return (a == ADDR_W'(num_regs - 1)) ? '0 : a + 1'b1;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and flags CS/SCLK edges.
module spi_edge_sync
  import spi_reg_bank_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs_n,
  input  logic spi_clk,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic cs_fall,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_prev;
  logic                   sclk_prev;

  // CS resets to "selected" so a frame already running at reset release
  // cannot produce a falling edge until CS has really been seen high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_n_s    = cs_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_n_s;
  assign sclk_rise = ~sclk_prev & sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank with RW/RO registers and a sticky interrupt register.
// Optional feature: define SPI_REG_BANK_BURST_EN for auto-incrementing multi-word transfers.
module spi_reg_bank
  import spi_reg_bank_pkg::*;
#(
  parameter int                  NUM_REGS   = 32,
  parameter int                  DATA_W     = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [ADDR_W-1:0]   IRQ_ADDR   = 7'h13,
  parameter logic [DATA_W-1:0]   DEFAULT_RD = 'h99
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       spi_cs_n,
  input  logic                       spi_clk,
  input  logic                       spi_mosi,
  output logic                       spi_miso,
  output logic                       spi_miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic [NUM_REGS*DATA_W-1:0] ro_data,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic [NUM_REGS-1:0]        rd_stb,
  input  logic [DATA_W-1:0]          irq_src,
  output logic                       irq
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] HDR  = ST_HDR;
  localparam logic [1:0] DATA = ST_DATA;
  localparam logic [1:0] DONE = ST_DONE;

  logic cs_n_s, cs_fall, sclk_rise, sclk_fall, mosi_s;

  spi_edge_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .cs_n_s    (cs_n_s),
    .cs_fall   (cs_fall),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s)
  );

  logic [1:0]          state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-2:0]   shift_in;
  logic [DATA_W-1:0]   shift_out;
  logic [ADDR_W-1:0]   addr;
  logic                is_read;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   irq_pend;
  logic [DATA_W-1:0]   irq_clr_mask;
  logic                irq_clr;

  logic                rise_sel;
  logic                hdr_last;
  logic                word_done;
  logic                wr_commit;
  logic                rd_load;
  logic                hdr_is_read;
  logic                rd_is_irq;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   wr_word;
  logic [DATA_W-1:0]   rd_word;
  logic [NUM_REGS-1:0] rd_hit;
  logic [NUM_REGS-1:0] wr_hit;

  // The last shifted bit arrives with the completing edge, so header/word
  // values are assembled from shift_in plus the current mosi sample.
  assign rise_sel    = ~cs_n_s & sclk_rise;
  assign hdr_addr    = {shift_in[ADDR_W-2:0], mosi_s};
  assign hdr_is_read = shift_in[RW_BIT-1];
  assign wr_word     = {shift_in, mosi_s};
  assign hdr_last    = rise_sel & (state == HDR)  & (bit_cnt == CNT_W'(HDR_W - 1));
  assign word_done   = rise_sel & (state == DATA) & (bit_cnt == CNT_W'(DATA_W - 1));
  assign wr_commit   = word_done & ~is_read;

`ifdef SPI_REG_BANK_BURST_EN
  assign rd_load = (hdr_last & hdr_is_read) | (word_done & is_read);
  assign rd_addr = (state == HDR) ? hdr_addr : next_addr(addr, NUM_REGS);
`else
  assign rd_load = hdr_last & hdr_is_read;
  assign rd_addr = hdr_addr;
`endif

  always_comb begin
    rd_word   = DEFAULT_RD;
    rd_hit    = '0;
    wr_hit    = '0;
    rd_is_irq = (rd_addr == IRQ_ADDR);
    for (int n = 0; n < NUM_REGS; n++) begin
      if (rd_addr == ADDR_W'(n)) begin
        rd_hit[n] = 1'b1;
        rd_word   = RO_MASK[n] ? ro_data[n*DATA_W +: DATA_W] : regs[n];
      end
      if (addr == ADDR_W'(n)) begin
        wr_hit[n] = 1'b1;
      end
    end
    if (rd_is_irq) begin
      rd_word = irq_pend;
    end
  end

  // MISO skips the fall right after a load: that fall only presents the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      is_read      <= 1'b0;
      spi_miso_oe  <= 1'b0;
      wr_stb       <= '0;
      rd_stb       <= '0;
      irq_clr      <= 1'b0;
      irq_clr_mask <= '0;
    end else begin
      wr_stb  <= '0;
      rd_stb  <= '0;
      irq_clr <= 1'b0;
      if (cs_n_s) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= HDR;
              bit_cnt <= '0;
            end
          end
          HDR: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[DATA_W-3:0], mosi_s};
              if (hdr_last) begin
                state   <= DATA;
                bit_cnt <= '0;
                addr    <= hdr_addr;
                is_read <= hdr_is_read;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_in <= {shift_in[DATA_W-3:0], mosi_s};
              if (word_done) begin
                bit_cnt <= '0;
                if (wr_commit) begin
                  wr_stb <= wr_hit;
                end
`ifdef SPI_REG_BANK_BURST_EN
                addr <= next_addr(addr, NUM_REGS);
`else
                state       <= DONE;
                spi_miso_oe <= 1'b0;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && is_read && bit_cnt != '0) begin
              shift_out <= {shift_out[DATA_W-2:0], 1'b0};
            end
          end
          default: begin
          end
        endcase
        if (rd_load) begin
          shift_out    <= rd_word;
          spi_miso_oe  <= 1'b1;
          rd_stb       <= rd_hit;
          irq_clr      <= rd_is_irq;
          irq_clr_mask <= irq_pend;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs[n] <= '0;
      end
    end else if (wr_commit) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (wr_hit[n] && !RO_MASK[n] && (ADDR_W'(n) != IRQ_ADDR)) begin
          regs[n] <= wr_word;
        end
      end
    end
  end

  // Only the bits handed out by the read are cleared; new sets always win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= '0;
    end else begin
      irq_pend <= (irq_pend & ~({DATA_W{irq_clr}} & irq_clr_mask)) | irq_src;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  assign irq      = |irq_pend;
  assign spi_miso = spi_miso_oe & shift_out[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: SPI master stimulus, strobe/MISO monitor.
module tb_spi_reg_bank;

  localparam logic [7:0] EV_WR = 8'd1;
  localparam logic [7:0] EV_RD = 8'd2;
  localparam logic [7:0] EV_RX = 8'd3;

  logic         clk;
  logic         reset_n;
  logic         spi_cs_n;
  logic         spi_clk;
  logic         spi_mosi;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic [255:0] reg_q;
  logic [255:0] ro_data;
  logic [31:0]  wr_stb;
  logic [31:0]  rd_stb;
  logic [7:0]   irq_src;
  logic         irq;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [31:0]  exp_q[$];
  logic [7:0]   rx_q[$];

  spi_reg_bank #(
    .NUM_REGS (32),
    .DATA_W   (8),
    .RO_MASK  (32'h0000_0020)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_q       (reg_q),
    .ro_data     (ro_data),
    .wr_stb      (wr_stb),
    .rd_stb      (rd_stb),
    .irq_src     (irq_src),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] regByte(input int n);
    return reg_q[n*8 +: 8];
  endfunction

  function automatic logic [7:0] onehotIdx(input logic [31:0] v);
    logic [7:0] r;
    r = 8'hFF;
    if ($onehot(v)) begin
      for (int i = 0; i < 32; i++) begin
        if (v[i]) r = 8'(i);
      end
    end
    return r;
  endfunction

  task automatic expectEvent(input logic [7:0] kind, input logic [7:0] idx, input logic [15:0] data);
    exp_q.push_back({kind, idx, data});
  endtask

  task automatic report(input logic [31:0] obs);
    if (exp_q.size() == 0) checkOutput("unexpected_event", obs, 32'h0);
    else checkOutput("event", obs, exp_q.pop_front());
  endtask

  // Monitor: every strobe and every received MISO word consumes one expectation.
  always @(negedge clk) begin
    logic [7:0] idx;
    if (rx_q.size() != 0) report({EV_RX, 8'h00, 8'h00, rx_q.pop_front()});
    if (|rd_stb) report({EV_RD, onehotIdx(rd_stb), 16'h0000});
    if (|wr_stb) begin
      idx = onehotIdx(wr_stb);
      report({EV_WR, idx, 8'h00, (idx < 8'd32) ? regByte(int'(idx)) : 8'h00});
    end
  end

  task automatic clockBit(input logic b, output logic m);
    spi_mosi = b;
    #80;
    spi_clk = 1'b1;
    m = spi_miso;
    #80;
    spi_clk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] hdr, input logic [15:0] dat, input int nbits, input bit expect_rx);
    logic       m;
    logic [7:0] rx;
    rx = 8'h00;
    spi_cs_n = 1'b0;
    #80;
    for (int k = 0; k < 8; k++) clockBit(hdr[7-k], m);
    for (int k = 0; k < nbits; k++) begin
      clockBit(dat[15-k], m);
      rx = {rx[6:0], m};
      if (expect_rx && (k % 8 == 7)) rx_q.push_back(rx);
    end
    #80;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #200;
  endtask

  task automatic irqReadRepulse();
    bit seen;
    seen = 1'b0;
    expectEvent(EV_RD, 8'h13, 16'h0000);
    expectEvent(EV_RX, 8'h00, 16'h0004);
    fork
      applyStimulus(8'h93, 16'h0000, 8, 1'b1);
      begin
        for (int c = 0; c < 400 && !seen; c++) begin
          @(negedge clk);
          if (rd_stb[19]) seen = 1'b1;
        end
        if (seen) begin
          irq_src = 8'h04;
          @(negedge clk);
          irq_src = 8'h00;
        end
      end
    join
    checkOutput("irq_rdstb_seen", 32'(seen), 32'h1);
    checkOutput("irq_kept_after_repulse", 32'(irq), 32'h1);
  endtask

  initial begin
    logic        m;
    logic [15:0] pre;
    clk      = 1'b0;
    reset_n  = 1'b0;
    spi_cs_n = 1'b0;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    irq_src  = 8'h00;
    ro_data  = '0;
    ro_data[5*8 +: 8] = 8'h3C;
    #22;
    checkOutput("rst_reg_q", 32'(|reg_q), 32'h0);
    checkOutput("rst_wr_stb", wr_stb, 32'h0);
    checkOutput("rst_rd_stb", rd_stb, 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_miso_oe", 32'(spi_miso_oe), 32'h0);
    checkOutput("rst_miso", 32'(spi_miso), 32'h0);
    reset_n = 1'b1;

    $display("[TB] frame already in progress at reset release");
    pre = 16'h0277;
    for (int k = 0; k < 16; k++) clockBit(pre[15-k], m);
    spi_cs_n = 1'b1;
    #300;
    checkOutput("pre_reset_frame_ignored", 32'(regByte(2)), 32'h0);

    $display("[TB] write/read register 2");
    expectEvent(EV_WR, 8'd2, 16'h00A5);
    applyStimulus(8'h02, 16'hA500, 8, 1'b0);
    checkOutput("reg2_written", 32'(regByte(2)), 32'hA5);
    expectEvent(EV_RD, 8'd2, 16'h0000);
    expectEvent(EV_RX, 8'h00, 16'h00A5);
    applyStimulus(8'h82, 16'h0000, 8, 1'b1);
    checkOutput("miso_oe_after_read", 32'(spi_miso_oe), 32'h0);

    $display("[TB] read-only register 5");
    expectEvent(EV_WR, 8'd5, 16'h0000);
    applyStimulus(8'h05, 16'hFF00, 8, 1'b0);
    checkOutput("ro_reg5_unchanged", 32'(regByte(5)), 32'h0);
    expectEvent(EV_RD, 8'd5, 16'h0000);
    expectEvent(EV_RX, 8'h00, 16'h003C);
    applyStimulus(8'h85, 16'h0000, 8, 1'b1);

    $display("[TB] sticky interrupt register");
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = 8'h00;
    @(negedge clk);
    checkOutput("irq_set", 32'(irq), 32'h1);
    expectEvent(EV_RD, 8'h13, 16'h0000);
    expectEvent(EV_RX, 8'h00, 16'h0004);
    applyStimulus(8'h93, 16'h0000, 8, 1'b1);
    checkOutput("irq_cleared", 32'(irq), 32'h0);
    @(negedge clk);
    irq_src = 8'h04;
    @(negedge clk);
    irq_src = 8'h00;
    irqReadRepulse();
    expectEvent(EV_RD, 8'h13, 16'h0000);
    expectEvent(EV_RX, 8'h00, 16'h0004);
    applyStimulus(8'h93, 16'h0000, 8, 1'b1);
    checkOutput("irq_cleared_again", 32'(irq), 32'h0);

    $display("[TB] unmapped read and aborted write");
    expectEvent(EV_RX, 8'h00, 16'h0099);
    applyStimulus(8'hFF, 16'h0000, 8, 1'b1);
    expectEvent(EV_WR, 8'd3, 16'h005A);
    applyStimulus(8'h03, 16'h5A00, 8, 1'b0);
    applyStimulus(8'h03, 16'hF000, 4, 1'b0);
    checkOutput("partial_write_discarded", 32'(regByte(3)), 32'h5A);

    $display("[TB] two-word write at the top address");
    expectEvent(EV_WR, 8'd31, 16'h0011);
`ifdef SPI_REG_BANK_BURST_EN
    expectEvent(EV_WR, 8'd0, 16'h0022);
`endif
    applyStimulus(8'h1F, 16'h1122, 16, 1'b0);
    checkOutput("reg31_written", 32'(regByte(31)), 32'h11);
`ifdef SPI_REG_BANK_BURST_EN
    checkOutput("reg0_burst_wrap", 32'(regByte(0)), 32'h22);
`else
    checkOutput("reg0_untouched", 32'(regByte(0)), 32'h0);
`endif

    #500;
    checkOutput("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: number of addressable registers, 2..128.
REQ-002 SHALL have parameter DATA_W, default 8: data word width in bits, 8 or 16.
REQ-003 SHALL have parameter RO_MASK, NUM_REGS bits, default 0: bit n=1 makes register n read-only, sourced from ro_data.
REQ-004 SHALL have parameter IRQ_ADDR, default 7'h13: address of the sticky interrupt register.
REQ-005 SHALL have parameter DEFAULT_RD, DATA_W bits, default 'h99: read value for unmapped addresses.
REQ-006 SHALL have port clk, input, 1 bit: single system clock; every flop is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have ports spi_cs_n, spi_clk, spi_mosi, all inputs, 1 bit each: SPI mode 0, CS active-low, asynchronous to clk.
REQ-009 SHALL have port spi_miso, output, 1 bit, plus port spi_miso_oe, output, 1 bit: the tristate enable for spi_miso.
REQ-010 SHALL have port reg_q, output, NUM_REGS*DATA_W bits: flattened RW register contents, register n at [n*DATA_W +: DATA_W].
REQ-011 SHALL have port ro_data, input, NUM_REGS*DATA_W bits: read-only sources, same packing as reg_q.
REQ-012 SHALL have ports wr_stb and rd_stb, outputs, NUM_REGS bits each: one-hot, one-clk pulse per word written or read.
REQ-013 SHALL have port irq_src, input, DATA_W bits: level interrupt sources.
REQ-014 SHALL have port irq, output, 1 bit: OR of the pending interrupt bits.

Function
REQ-015 SHALL pass spi_cs_n, spi_clk and spi_mosi through 2-FF synchronisers and detect sclk edges in the clk domain; clk SHALL be at least 8x spi_clk.
REQ-016 SHALL run an FSM with states IDLE, HDR, DATA and DONE.
- IDLE -> HDR on the synced CS falling edge.
- Any state -> IDLE on CS high.
REQ-017 SHALL sample mosi MSB-first on sclk rising edges.
- Header is 8 bits: bit7=1 read, bit7=0 write; bits6:0 address.
- HDR -> DATA after the 8th header bit.
REQ-018 On a read, SHALL load the shift-out register in the clk cycle after the 8th header rise, assert spi_miso_oe, drive the MSB, and shift on each subsequent sclk falling edge.
REQ-019 On a read, SHALL pulse rd_stb[addr] in the same cycle as that load.
REQ-020 On a write, SHALL update reg_q[addr] and pulse wr_stb[addr] in the clk cycle after the DATA_W-th data rising edge; RO registers SHALL still pulse wr_stb but keep reg_q unchanged.
REQ-021 SHALL make addresses >= NUM_REGS read DEFAULT_RD; writes to them SHALL have no effect and no strobe.
REQ-022 SHALL discard a partial word on CS rise mid-word: no strobe, no register update.
REQ-023 SHALL hold spi_miso_oe low whenever CS is high or a write transaction is in progress.
REQ-024 Interrupt register: SHALL set pending bit i each clk while irq_src[i]=1.
- Reading IRQ_ADDR returns the pending bits, then clears exactly the bits returned, one cycle after rd_stb.
- A bit that sets in the clear cycle SHALL remain set.
- Writes to IRQ_ADDR SHALL be ignored.

Reset
REQ-025 While reset_n is low, SHALL force reg_q=0, irq pending=0, wr_stb=0, rd_stb=0, irq=0, spi_miso_oe=0, spi_miso=0, FSM=IDLE.
REQ-026 After reset release, SHALL ignore any transaction already in progress until CS has been seen high.

Configuration
REQ-027 With SPI_REG_BANK_BURST_EN defined, DATA SHALL continue after each word:
- Address increments per word and wraps NUM_REGS-1 -> 0.
- Strobes and the read reload repeat per word.
- Interrupt clearing applies per IRQ_ADDR word.
REQ-028 Without SPI_REG_BANK_BURST_EN, SHALL go DATA -> DONE after one word and ignore further sclk until CS rises, with miso_oe low in DONE.

Structure
REQ-029 SHALL define the FSM state enum, HDR_W=8, RW bit index and SYNC_STAGES=2 in package spi_reg_bank_pkg.
REQ-030 SHALL instantiate one sub-module, spi_edge_sync, for synchronisation and edge detection of cs/sclk/mosi.

Verification
REQ-031 Write 0x02 data 0xA5 -> reg_q[2]=0xA5 and a single wr_stb[2] pulse.
REQ-032 Read 0x02 after that write -> miso returns 0xA5 and a single rd_stb[2] pulse.
REQ-033 RO_MASK bit 5 set, ro_data[5]=0x3C:
- Write 0x05 data 0xFF -> reg_q[5] stays 0 and wr_stb[5] pulses.
- Read 0x05 -> 0x3C.
REQ-034 irq_src=0x04 pulse for 1 cycle -> irq=1; read IRQ_ADDR -> 0x04, then irq=0.
- Re-pulsing irq_src during the clear cycle leaves bit 2 set.
REQ-035 Read 0x7F with NUM_REGS=32 -> 0x99 and no rd_stb.
- Write header 0x03 then 4 data bits then CS high -> reg_q[3] unchanged, no strobe.
REQ-036 Burst (SPI_REG_BANK_BURST_EN), NUM_REGS=32:
- Write at 0x1F with 0x11, 0x22 -> reg_q[31]=0x11, reg_q[0]=0x22.
- Same stimulus without the macro -> only reg_q[31] written.
